// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a 4-word line and a single outstanding refill.
// Hits are answered combinationally; misses stall fetch until the line is installed.
module instr_cache #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          read,
  input  logic [31:0]   address,
  output logic [31:0]   instruction,
  output logic          busywait,
  output logic          mem_read,
  output logic [27:0]   mem_address,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int unsigned Lines   = 2 ** INDEX_BITS;
  localparam int unsigned TagBits = 28 - INDEX_BITS;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

  state_e state_q, state_d;

  logic [TagBits-1:0]    tag;
  logic [INDEX_BITS-1:0] index;
  logic [1:0]            word;
  logic                  unused_addr;

  logic [Lines-1:0]   valid_q;
  logic [TagBits-1:0] tag_q  [Lines];
  logic [127:0]       data_q [Lines];
  logic [127:0]       line_q, line_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic               hit;

  assign tag         = address[31:4+INDEX_BITS];
  assign index       = address[3+INDEX_BITS:4];
  assign word        = address[3:2];
  assign unused_addr = ^address[1:0];

  assign hit = read & valid_q[index] & (tag_q[index] == tag) & (state_q == StIdle);

  assign instruction = hit ? data_q[index][{word, 5'b0} +: 32] : Nop;
  assign busywait    = read & ~hit;
  assign mem_address = address[31:4];
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    mem_read     = 1'b0;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    unique case (state_q)
      StIdle: begin
        if (read && !hit) begin
          state_d = StMemRead;
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
        end
        if (hit && hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
      end
      StMemRead: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          line_d  = mem_readdata;
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (state_q == StUpdate) valid_q[index] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; a reset during UPDATE must still suppress the install.
  always_ff @(posedge CLK) begin
    line_q <= line_d;
    if (!RESET && state_q == StUpdate) begin
      tag_q[index]  <= tag;
      data_q[index] <= line_q;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: cold/conflict misses, same-line hits, idle requests,
// reset during a refill and hit counter saturation.
module tb_instr_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         read = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [127:0] LineA = {32'h0040_0093, 32'h0030_0113, 32'h0020_0193, 32'h0010_0213};
  localparam logic [127:0] LineB = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
  localparam logic [127:0] LineC = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};

  instr_cache #(.INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: holds mem_busywait high for the first nbusy stall cycles of the request,
  // starting with the cycle in which the miss is first seen.
  task automatic refill(input logic [31:0] a, input logic [127:0] line, input int nbusy,
                        output int stalls, output logic [27:0] req_addr, output int req_seen);
    read         = 1'b1;
    address      = a;
    mem_readdata = line;
    stalls       = 0;
    req_seen     = 0;
    req_addr     = '1;
    for (int i = 0; i < 60; i++) begin
      mem_busywait = (i < nbusy);
      #1;
      if (!busywait) break;
      stalls++;
      if (mem_read && req_seen == 0) begin
        req_seen = 1;
        req_addr = mem_address;
      end
      @(negedge CLK);
    end
    mem_busywait = 1'b0;
  endtask

  int          stalls;
  logic [27:0] req_addr;
  int          req_seen;

  initial begin
    // Reset
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_busywait_idle", {31'd0, busywait}, 32'd0);
    read = 1'b1;
    address = 32'h0;
    #1;
    chk("rst_busywait_read", {31'd0, busywait}, 32'd1);
    chk("rst_instr_nop", instruction, Nop);

    // Cold miss
    refill(32'h0, LineA, 3, stalls, req_addr, req_seen);
    chk("cold_stalls", stalls, 32'd5);
    chk("cold_req_seen", req_seen, 32'd1);
    chk("cold_mem_addr", {4'd0, req_addr}, 32'h0);
    chk("cold_instr", instruction, 32'h0010_0213);
    chk("cold_busywait", {31'd0, busywait}, 32'd0);
    chk("cold_miss_count", miss_count, 32'd1);

    // Same-line hits
    @(negedge CLK);
    chk("hit0_count", hit_count, 32'd1);
    address = 32'h4;
    #1;
    chk("hit4_instr", instruction, 32'h0020_0193);
    chk("hit4_busywait", {31'd0, busywait}, 32'd0);
    chk("hit4_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge CLK);
    chk("hit4_count", hit_count, 32'd2);
    address = 32'h8;
    #1;
    chk("hit8_instr", instruction, 32'h0030_0113);
    chk("hit8_busywait", {31'd0, busywait}, 32'd0);
    @(negedge CLK);
    chk("hit8_count", hit_count, 32'd3);
    address = 32'hC;
    #1;
    chk("hitc_instr", instruction, 32'h0040_0093);
    chk("hitc_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge CLK);
    chk("hitc_count", hit_count, 32'd4);

    // Idle request
    read = 1'b0;
    address = 32'h0000_0080;
    #1;
    chk("idle_busywait", {31'd0, busywait}, 32'd0);
    chk("idle_instr", instruction, Nop);
    chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge CLK);
    address = 32'h0000_0004;
    #1;
    chk("idle_instr_cached", instruction, Nop);
    @(negedge CLK);
    chk("idle_hit_count", hit_count, 32'd4);
    chk("idle_miss_count", miss_count, 32'd1);

    // Conflict miss: 0x80 evicts index 0, then 0x0 must refill again
    refill(32'h0000_0080, LineB, 2, stalls, req_addr, req_seen);
    chk("conf1_stalls", stalls, 32'd4);
    chk("conf1_mem_addr", {4'd0, req_addr}, 32'h0000_0008);
    chk("conf1_instr", instruction, 32'hAAAA_0000);
    @(negedge CLK);
    refill(32'h0000_0000, LineA, 1, stalls, req_addr, req_seen);
    chk("conf2_stalls", stalls, 32'd3);
    chk("conf2_req_seen", req_seen, 32'd1);
    chk("conf2_mem_addr", {4'd0, req_addr}, 32'h0);
    chk("conf2_instr", instruction, 32'h0010_0213);
    @(negedge CLK);
    read = 1'b0;
    #1;
    chk("conf_miss_count", miss_count, 32'd3);
    chk("conf_hit_count", hit_count, 32'd6);

    // Reset mid-refill
    @(negedge CLK);
    read = 1'b1;
    address = 32'h0000_0100;
    mem_busywait = 1'b1;
    mem_readdata = LineC;
    @(negedge CLK);
    chk("mid_mem_read", {31'd0, mem_read}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    mem_busywait = 1'b0;
    #1;
    chk("mid_mem_read_after", {31'd0, mem_read}, 32'd0);
    chk("mid_hit_count", hit_count, 32'd0);
    chk("mid_miss_count", miss_count, 32'd0);
    chk("mid_busywait", {31'd0, busywait}, 32'd1);
    chk("mid_instr", instruction, Nop);
    refill(32'h0000_0100, LineC, 1, stalls, req_addr, req_seen);
    chk("mid_re_stalls", stalls, 32'd3);
    chk("mid_re_mem_addr", {4'd0, req_addr}, 32'h0000_0010);
    chk("mid_re_instr", instruction, 32'hCCCC_0000);
    chk("mid_re_miss_count", miss_count, 32'd1);
    @(negedge CLK);
    read = 1'b0;

    // Saturation
    force dut.hit_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_count_q;
    @(negedge CLK);
    chk("sat_preload", hit_count, 32'hFFFF_FFFE);
    read = 1'b1;
    address = 32'h0000_0108;
    #1;
    chk("sat_instr", instruction, 32'hCCCC_0002);
    @(negedge CLK);
    chk("sat_first", hit_count, 32'hFFFF_FFFF);
    @(negedge CLK);
    @(negedge CLK);
    read = 1'b0;
    #1;
    chk("sat_final", hit_count, 32'hFFFF_FFFF);
    chk("sat_miss_count", miss_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped instruction cache. Answers the fetch stage's PC requests and refills lines from main instruction memory on a miss.
- Sits between the fetch stage's `pc_out` and the instruction memory port.
- Returns `instruction` on a hit in the same cycle.
- Asserts `busywait` on a miss so the fetch stage freezes the PC until the line is refilled.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines).
- Line size is fixed at 4 words (128 bits). Offset is 4 bits. TAG_BITS = 28 - INDEX_BITS.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- read  input  1  fetch request valid
- address  input  32  byte address (PC) from fetch stage
- instruction  output  32  fetched instruction word
- busywait  output  1  high = fetch must stall and hold `address`
- mem_read  output  1  refill request to instruction memory
- mem_address  output  28  line address, equal to `address[31:4]`
- mem_readdata  input  128  refill line; word0 in [31:0], word3 in [127:96]
- mem_busywait  input  1  high while memory is servicing `mem_read`
- hit_count  output  32  number of hit cycles, saturating
- miss_count  output  32  number of misses started, saturating

Behaviour:
- Address split:
  - tag = `address[31:4+INDEX_BITS]`
  - index = `address[3+INDEX_BITS:4]`
  - word = `address[3:2]`
  - `address[1:0]` is ignored.
- Storage per line: valid bit, tag, 128-bit data. No write path from the CPU side.
- hit = `read` & valid[index] & (tag_array[index] == tag) & (state == IDLE).
- Outputs (combinational):
  - `instruction` = selected word when hit, else 32'h00000013 (NOP).
  - `busywait` = `read` & ~hit.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - `mem_read` = 0.
    - If `read` & ~hit: go to MEM_READ and increment miss_count.
    - If hit: increment hit_count.
    - If `read` = 0: stay in IDLE; `busywait` = 0; no counter change.
  - MEM_READ:
    - `mem_read` = 1 and `mem_address` = `address[31:4]`, both held stable.
    - Stay while `mem_busywait` = 1.
    - When `mem_busywait` = 0: register `mem_readdata`, go to UPDATE.
  - UPDATE:
    - `mem_read` = 0.
    - On the edge, write data, tag and valid=1 to line[index].
    - Go to IDLE. `busywait` stays 1 during UPDATE.
- Timing:
  - Hit latency is 0 cycles (combinational).
  - Miss penalty is N+2 stall cycles, where N is the number of cycles with `mem_busywait` high. The request hits on the first IDLE cycle after UPDATE.
- Fetch contract: `address` and `read` are held constant while `busywait` = 1. The block does not need to tolerate address changes mid-refill. A branch redirect is applied by the fetch stage only after `busywait` falls.
- `mem_address` = `address[31:4]` in all states. It is meaningful only when `mem_read` = 1.
- Conflict miss: a miss whose index matches a valid line with a different tag overwrites that line. No victim writeback.
- Counters saturate at 32'hFFFFFFFF and do not wrap.
- RESET (synchronous, priority over everything):
  - state ← IDLE; all valid bits ← 0; hit_count ← 0; miss_count ← 0.
  - Tag and data arrays need not be cleared.
  - Outputs after reset: `mem_read` = 0. With `read` = 1, `busywait` = 1 and `instruction` = NOP, since every access misses.
- RESET asserted in MEM_READ or UPDATE:
  - Abandons the refill; the line is not written.
  - `mem_read` is low the cycle after the reset edge.
  - A late `mem_busywait` falling edge from memory is ignored.

Test Plan:
- Cold miss:
  - Stimulus: reset, then `read` = 1, `address` = 0x00000000; memory returns line {0x00400093, 0x00300113, 0x00200193, 0x00100213} (word3..word0) with `mem_busywait` high for 3 cycles.
  - Required: `mem_read` = 1 with `mem_address` = 0x0000000; `busywait` high for 5 cycles; then `instruction` = 0x00100213, `busywait` = 0, miss_count = 1.
- Same-line hits:
  - Stimulus: after the cold-miss test, step `address` 0x4, 0x8, 0xC.
  - Required: `instruction` = 0x00200193, 0x00300113, 0x00400093, each in the same cycle; `busywait` = 0; hit_count increments by 1 per cycle; `mem_read` stays 0.
- Conflict miss:
  - Stimulus: with INDEX_BITS = 3, access 0x00000080 (same index 0, new tag), then 0x00000000.
  - Required: both accesses miss; miss_count increases by 2; the second refill reissues `mem_address` = 0x0000000.
- Idle request:
  - Stimulus: `read` = 0 for any `address`.
  - Required: `busywait` = 0, `instruction` = 0x00000013, counters unchanged, `mem_read` = 0.
- Reset mid-refill:
  - Stimulus: assert RESET for 1 cycle while in MEM_READ.
  - Required: `mem_read` = 0 the next cycle; both counters = 0; a re-access of the same address misses again.
- Saturation:
  - Stimulus: force hit_count to 0xFFFFFFFE, then issue 3 hits.
  - Required: hit_count ends at 0xFFFFFFFF.
